// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, default memory
// depth and the saturating increment used by the access counters.
package load_store_unit_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam int DEF_MEM_DEPTH = 201;
  localparam int CNT_W         = 16;

  typedef enum logic [1:0] {
    S_IDLE    = IDLE,
    S_ISSUE   = ISSUE,
    S_CAPTURE = CAPTURE,
    S_DONE    = DONE
  } lsu_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response signals and data-memory port of the load/store unit.
// slave = the unit itself; master = core plus data memory.
interface load_store_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              Req;
  logic              Wr;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WData;
  logic              Ready;
  logic              Done;
  logic              Err;
  logic [DATA_W-1:0] RData;

  logic [ADDR_W-1:0] Mem_Address;
  logic [DATA_W-1:0] Mem_Write_Data;
  logic              Mem_MemWrite;
  logic [DATA_W-1:0] Mem_Read_Data;

  modport slave (
    input  Req, Wr, Addr, WData, Mem_Read_Data,
    output Ready, Done, Err, RData, Mem_Address, Mem_Write_Data, Mem_MemWrite
  );

  modport master (
    output Req, Wr, Addr, WData, Mem_Read_Data,
    input  Ready, Done, Err, RData, Mem_Address, Mem_Write_Data, Mem_MemWrite
  );

endinterface

// File: rtl/load_store_unit_sat_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter
  import load_store_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = sat_inc(count_q);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store sequencer between a core and a data memory
// with registered read data; reports out-of-range accesses and counts hits.
//
// state   | meaning
// IDLE    | Ready=1, accept Req, range-check address
// ISSUE   | address/data on memory port, write strobe for stores
// CAPTURE | memory read data valid, latch into RData
// DONE    | one-cycle Done (Err if out of range), bump counters
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic                 Clk,
  input  logic                 Reset,
  load_store_unit_if.slave     bus,
  output logic [CNT_W-1:0]     Rd_Count,
  output logic [CNT_W-1:0]     Wr_Count
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic req_oor;
  logic rd_inc;
  logic wr_inc;

  // One extra bit so a MEM_DEPTH of 2**ADDR_W still compares correctly.
  assign req_oor = ({1'b0, bus.Addr} >= DEPTH_L);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Req) begin
          addr_d  = bus.Addr;
          wdata_d = bus.WData;
          wr_d    = bus.Wr;
          err_d   = req_oor;
          state_d = req_oor ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE:   state_d = wr_q ? S_DONE : S_CAPTURE;
      S_CAPTURE: begin
        rdata_d = bus.Mem_Read_Data;
        state_d = S_DONE;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.Ready          = (state_q == S_IDLE);
  assign bus.Done           = (state_q == S_DONE);
  assign bus.Err            = (state_q == S_DONE) && err_q;
  assign bus.RData          = rdata_q;
  assign bus.Mem_Address    = addr_q;
  assign bus.Mem_Write_Data = wdata_q;
  // Reset gates the strobe directly so a store aborted in ISSUE never lands.
  assign bus.Mem_MemWrite   = (state_q == S_ISSUE) && wr_q && !Reset;

  assign rd_inc = (state_q == S_DONE) && !err_q && !wr_q;
  assign wr_inc = (state_q == S_DONE) && !err_q &&  wr_q;

  sat_counter u_rd_cnt (
    .clk   (Clk),
    .rst   (Reset),
    .inc   (rd_inc),
    .count (Rd_Count)
  );

  sat_counter u_wr_cnt (
    .clk   (Clk),
    .rst   (Reset),
    .inc   (wr_inc),
    .count (Wr_Count)
  );

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width.
REQ-003 SHALL have parameter MEM_DEPTH, default 201, number of valid data-memory words (legal addresses 0..MEM_DEPTH-1).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 Clk  input  1  rising-edge clock, shared with the data memory.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 Req  input  1  core access request, sampled only while Ready=1.
REQ-008 Wr  input  1  1=store, 0=load; sampled with Req.
REQ-009 Addr  input  ADDR_W  word address; sampled with Req.
REQ-010 WData  input  DATA_W  store data; sampled with Req.
REQ-011 Ready  output  1  unit idle, able to accept Req.
REQ-012 Done  output  1  one-cycle completion pulse.
REQ-013 Err  output  1  out-of-range flag; valid only while Done=1.
REQ-014 RData  output  DATA_W  last loaded word, held until the next successful load.
REQ-015 Rd_Count  output  16  saturating count of completed in-range loads.
REQ-016 Wr_Count  output  16  saturating count of completed in-range stores.
REQ-017 Mem_Address  output  ADDR_W  data-memory address.
REQ-018 Mem_Write_Data  output  DATA_W  data-memory write data.
REQ-019 Mem_MemWrite  output  1  data-memory write enable.
REQ-020 Mem_Read_Data  input  DATA_W  data-memory registered read data, valid the cycle after the address is presented with Mem_MemWrite=0.

Function
REQ-021 SHALL implement the FSM states IDLE, ISSUE, CAPTURE, DONE.
REQ-022 IDLE: Ready=1; on Req=1, SHALL latch Addr, WData and Wr into addr_q, wdata_q and wr_q; SHALL go to DONE with err_q=1 if Addr>=MEM_DEPTH, else go to ISSUE.
REQ-023 ISSUE: drive Mem_Address=addr_q and Mem_Write_Data=wdata_q; Mem_MemWrite=wr_q; next state DONE if wr_q=1, else CAPTURE.
REQ-024 CAPTURE: at the clock edge, RData<=Mem_Read_Data; next state DONE.
REQ-025 DONE: Done=1 and Err=err_q for exactly one cycle; increment Rd_Count or Wr_Count (saturate at 16'hFFFF, none on error); next state IDLE.
REQ-026 Latency from the accepting edge to Done: store 2 cycles, load 3 cycles, out-of-range 1 cycle.
REQ-027 Ready SHALL be 0 in every state except IDLE; Req while Ready=0 SHALL be ignored, with no queuing.
REQ-028 Mem_Address SHALL always equal addr_q; Mem_MemWrite SHALL be 0 in every state except ISSUE with wr_q=1.
REQ-029 An out-of-range access SHALL never assert Mem_MemWrite and SHALL leave RData unchanged.
REQ-030 Back-to-back: a Req held through DONE SHALL be accepted in the following IDLE cycle, giving one idle cycle between transactions.
REQ-031 Outputs Ready, Done, Err and Mem_MemWrite SHALL be decoded from the registered state only, with no combinational path from Req.

Reset
REQ-032 On Reset=1 at a clock edge: state=IDLE; addr_q, wdata_q, wr_q, err_q, RData, Rd_Count and Wr_Count all 0.
REQ-033 Mem_MemWrite SHALL be gated by !Reset, so a reset asserted during a store ISSUE cycle causes no memory write.
REQ-034 Reset mid-load SHALL abort the load: no Done, RData=0, count unchanged beyond reset.
REQ-035 Reset SHALL take priority over Req in the same cycle.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding (2-bit localparams IDLE=0, ISSUE=1, CAPTURE=2, DONE=3) and the default MEM_DEPTH.
REQ-037 A sub-module sat_counter (16-bit, inc, synchronous reset) SHALL be instantiated twice, once each for Rd_Count and Wr_Count.

Verification (bench instantiates the team data memory, preloaded word0=3, word1=4, word2=1, word3=2)
REQ-038 Load Addr=1 -> Done 3 cycles after accept; RData=4; Err=0; Rd_Count=1.
REQ-039 Store Addr=5, WData=16'hBEEF, then load Addr=5 -> store Done after 2 cycles; RData=16'hBEEF; Wr_Count=1, Rd_Count=1.
REQ-040 Store Addr=201, WData=7 -> Done+Err after 1 cycle; Mem_MemWrite never 1; Wr_Count=0; RData unchanged.
REQ-041 Reset asserted in the ISSUE cycle of a store to Addr=0 with WData=9 -> a later load Addr=0 returns 3; no Done from the aborted store.
REQ-042 Req held high for four loads Addr=0..3 -> RData sequence 3,4,1,2; each Done 4 cycles apart; Req ignored while Ready=0.
REQ-043 Force Rd_Count to 16'hFFFE, then perform three loads -> Rd_Count=16'hFFFF, with no wrap.
